regs_mp_sb: RTL
===============

Name: regs_mp_sb

Overview:
- Parametrised successor to the core register file: NR_RD combinational read ports, NR_WR write ports, optional write-to-read bypass, and a per-register scoreboard (busy bits).
- Sits between decode/issue (reads, reservations) and writeback (writes, busy clears) in the pipelined core.
- Lets issue logic detect RAW/WAW hazards without a separate scoreboard block.

Parameters:
- WIDTH, 32, data width of each register.
- NR_REGS, 32, number of architectural registers; must satisfy NR_REGS <= 2**ADDR_WIDTH.
- ADDR_WIDTH, 5, register address width.
- NR_RD, 2, number of read ports (1..8).
- NR_WR, 2, number of write ports (1..4).
- RESET_VAL, 0, reset value of registers 1..NR_REGS-1.
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy.
- BYPASS, 1, 1 = same-cycle write data forwarded to reads.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- raddr  in  NR_RD*ADDR_WIDTH  read addresses; port k at [k*ADDR_WIDTH +: ADDR_WIDTH].
- rdata  out  NR_RD*WIDTH  read data; port k at [k*WIDTH +: WIDTH].
- rbusy  out  NR_RD  per read port: register pending (value not yet valid).
- wen  in  NR_WR  per write port enable.
- waddr  in  NR_WR*ADDR_WIDTH  write addresses.
- wdata  in  NR_WR*WIDTH  write data.
- rsv_en  in  1  request to mark rsv_addr busy (destination reservation at issue).
- rsv_addr  in  ADDR_WIDTH  register to reserve.
- rsv_ok  out  1  reservation granted this cycle (combinational).
- flush  in  1  synchronous clear of all busy bits.
- busy  out  NR_REGS  scoreboard state, bit i = register i pending.

Behaviour:
- Reset: async on rst high. Registers 1..NR_REGS-1 get RESET_VAL, register 0 gets 0, busy all 0. Outputs follow combinationally: rdata = reset contents, rbusy = 0, rsv_ok = rsv_en.
- Writes: on rising clk, for each port j with wen[j], regs[waddr_j] <= wdata_j.
  - Same address on multiple enabled ports: highest port index wins.
  - waddr >= NR_REGS: write dropped.
  - ZERO_REG=1 and waddr==0: dropped.
- Reads: combinational, zero latency.
  - Address >= NR_REGS reads 0; ZERO_REG=1 and address 0 reads 0.
  - BYPASS=1: if any enabled write port targets raddr_k this cycle, rdata_k = wdata of the highest such port; otherwise the stored value.
  - BYPASS=0: always the stored value; new data is visible the cycle after the write edge.
- Busy clear: each enabled write to address a clears busy[a] at the clk edge.
- rbusy_k:
  - BYPASS=1: busy[raddr_k] AND NOT (any enabled write to raddr_k this cycle).
  - BYPASS=0: busy[raddr_k].
  - Always 0 for register 0 when ZERO_REG=1, and for out-of-range addresses.
- Reservation:
  - rsv_ok = rsv_en AND NOT flush AND NOT blocked.
  - blocked = busy[rsv_addr] AND NOT (enabled write to rsv_addr this cycle).
  - On the edge with rsv_ok=1, busy[rsv_addr] <= 1.
  - Set and clear of the same address in one cycle: set wins, so busy stays 1 for the new owner.
  - rsv_addr 0 with ZERO_REG=1, or out of range: rsv_ok = rsv_en AND NOT flush, no state change.
- Flush: on the edge with flush=1, all busy bits are cleared. Register writes in the same cycle still occur. rsv_ok is forced 0.
- Reset mid-operation: all pending reservations are lost, busy goes to 0 immediately, and register contents return to reset values.
- No internal pipeline; state is regs[NR_REGS] plus busy[NR_REGS].
- rsv_ok and rbusy have no dependency on any output, so no combinational loops are introduced.

Test Plan:
- Reset, then read all ports at addresses 0, 1, 31 with RESET_VAL=32'h5A -> rdata 0, 32'h5A, 32'h5A; busy=0; rbusy=0.
- Write port0 x3=32'h1111 and port1 x3=32'h2222 in the same cycle -> next cycle read x3 = 32'h2222. Write x0=32'hFFFF -> x0 reads 0.
- BYPASS=1: wen port0 x5=32'hABCD, read raddr0=5 in the same cycle -> rdata0=32'hABCD immediately. BYPASS=0: old value that cycle, 32'hABCD next cycle.
- Reserve x7 (rsv_ok=1) -> busy[7]=1, rbusy on raddr=7 is 1. Second rsv x7 -> rsv_ok=0. Write x7=32'h77 -> busy[7] cleared next cycle, and rbusy=0 in the write cycle (BYPASS=1).
- Same cycle: write x9 clears while rsv x9 sets, with busy[9]=1 beforehand -> rsv_ok=1, busy[9] stays 1.
- Reserve x2, x4, then assert flush together with rsv x6 -> busy all 0, rsv_ok=0. Assert rst asynchronously mid-cycle -> busy=0 and regs = RESET_VAL before the next edge.

Source files
------------

// File: rtl/regs_mp_sb.sv
// Multi-port register file with per-register scoreboard (busy bits).
// NR_RD combinational read ports, NR_WR write ports (highest index wins),
// optional write-to-read bypass, reservation port and busy flush.
module regs_mp_sb #(
   parameter int              WIDTH      = 32,
   parameter int              NR_REGS    = 32,
   parameter int              ADDR_WIDTH = 5,
   parameter int              NR_RD      = 2,
   parameter int              NR_WR      = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter int              ZERO_REG   = 1,
   parameter int              BYPASS     = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NR_RD*ADDR_WIDTH-1:0] raddr,
   output logic [NR_RD*WIDTH-1:0]      rdata,
   output logic [NR_RD-1:0]            rbusy,
   input  logic [NR_WR-1:0]            wen,
   input  logic [NR_WR*ADDR_WIDTH-1:0] waddr,
   input  logic [NR_WR*WIDTH-1:0]      wdata,
   input  logic                        rsv_en,
   input  logic [ADDR_WIDTH-1:0]       rsv_addr,
   output logic                        rsv_ok,
   input  logic                        flush,
   output logic [NR_REGS-1:0]          busy
);

   localparam int AW = ADDR_WIDTH;

   logic [NR_REGS-1:0][WIDTH-1:0] regs_q, regs_d;
   logic [NR_REGS-1:0]            busy_q, busy_d;

   // Per-register write hit and merged next value (highest port wins)
   logic [NR_REGS-1:0]            wr_hit;
   logic [NR_REGS-1:0]            rsv_set;

   // Register 0 is hardwired when ZERO_REG is set: no reads, writes or busy.
   function automatic logic reg_ok(input int i);
      return !(ZERO_REG != 0 && i == 0);
   endfunction

   // Resolve all write ports per register; later ports override earlier ones
   always_comb begin
      wr_hit = '0;
      regs_d = regs_q;
      for (int i = 0; i < NR_REGS; i++) begin
         for (int j = 0; j < NR_WR; j++) begin
            if (wen[j] && waddr[j*AW +: AW] == AW'(i) && reg_ok(i)) begin
               wr_hit[i] = 1'b1;
               regs_d[i] = wdata[j*WIDTH +: WIDTH];
            end
         end
      end
   end

   // Read ports: out-of-range and hardwired x0 read 0 and are never busy
   always_comb begin
      rdata = '0;
      rbusy = '0;
      for (int k = 0; k < NR_RD; k++) begin
         for (int i = 0; i < NR_REGS; i++) begin
            if (raddr[k*AW +: AW] == AW'(i) && reg_ok(i)) begin
               rdata[k*WIDTH +: WIDTH] = (BYPASS != 0) ? regs_d[i] : regs_q[i];
               rbusy[k] = busy_q[i] & ~((BYPASS != 0) & wr_hit[i]);
            end
         end
      end
   end

   // Reservation: blocked only by a busy register not being written now;
   // x0/out-of-range requests are granted but change no state
   always_comb begin
      rsv_ok  = rsv_en & ~flush;
      rsv_set = '0;
      for (int i = 0; i < NR_REGS; i++) begin
         if (rsv_addr == AW'(i) && reg_ok(i)) begin
            rsv_ok     = rsv_en & ~flush & ~(busy_q[i] & ~wr_hit[i]);
            rsv_set[i] = rsv_en & ~flush & ~(busy_q[i] & ~wr_hit[i]);
         end
      end
   end

   // Scoreboard next state: writes clear, reservation sets (set wins), flush clears all
   always_comb begin
      busy_d = (busy_q & ~wr_hit) | rsv_set;
      if (flush) busy_d = '0;
   end

   // State registers; async reset restores contents and drops all reservations
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs_q[0] <= '0;
         for (int i = 1; i < NR_REGS; i++) regs_q[i] <= RESET_VAL;
         busy_q <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
   end

   assign busy = busy_q;

endmodule
